// File: rtl/mem_arbiter.sv
// Shares the main-memory port between the I-cache refill path and the D-cache refill/write-back path.
// Optional ARB_RR_EN: contested requests alternate D/I instead of fixed D > I priority.
module mem_arbiter #(
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned MEM_LATENCY = 5,
  parameter int unsigned AW          = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_req,
  input  logic [AW-1:0]                 i_addr,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [AW-1:0]                 d_addr,
  input  logic [31:0]                   d_wdata,
  output logic                          i_gnt,
  output logic                          d_gnt,
  output logic                          beat_valid,
  output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
  output logic [31:0]                   rdata,
  output logic                          i_done,
  output logic                          d_done,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  output logic                          mem_ready
);

  localparam int unsigned   BW        = $clog2(LINE_WORDS);
  localparam int unsigned   OW        = BW + 2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [4:0]    LAT_LAST  = 5'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          own_d_q, own_d_d;
  logic          we_q, we_d;
  logic [AW-1:OW] base_q, base_d;
  logic [4:0]    lat_q, lat_d;
  logic [BW:0]   cnt_q, cnt_d;
  logic          rpend_q, rvalid_q;
  logic [BW-1:0] ridx_q, rvidx_q;
  logic [31:0]   rdata_q;
  logic          pick_d;
  logic          unused_addr_bits;

`ifdef ARB_RR_EN
  logic pri_i_q, pri_i_d, cont_q, cont_d;
  assign pick_d = d_req & ~(i_req & pri_i_q);
`else
  assign pick_d = d_req;
`endif

  assign unused_addr_bits = ^{i_addr[OW-1:0], d_addr[OW-1:0]};

  // cnt_q has one extra bit so a read burst can stop issuing while waiting for its last return
  assign mem_en     = (state_q == S_BURST) & ~cnt_q[BW];
  assign mem_we     = mem_en & we_q;
  assign mem_addr   = mem_en ? {base_q, cnt_q[BW-1:0], 2'b00} : '0;
  assign mem_wdata  = mem_we ? d_wdata : '0;
  assign beat_valid = we_q ? mem_we : rvalid_q;
  assign beat_idx   = ~beat_valid ? '0 : (we_q ? cnt_q[BW-1:0] : rvidx_q);
  assign rdata      = rdata_q;
  assign i_gnt      = (state_q != S_IDLE) & ~own_d_q;
  assign d_gnt      = (state_q != S_IDLE) & own_d_q;
  assign i_done     = (state_q == S_DONE) & ~own_d_q;
  assign d_done     = (state_q == S_DONE) & own_d_q;
  assign mem_ready  = ~reset | ((state_q == S_IDLE) & ~i_req & ~d_req);

  always_comb begin
    state_d = state_q;
    own_d_d = own_d_q;
    we_d    = we_q;
    base_d  = base_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
`ifdef ARB_RR_EN
    pri_i_d = pri_i_q;
    cont_d  = cont_q;
`endif
    case (state_q)
      S_IDLE: if (i_req | d_req) begin
        state_d = S_WAIT;
        own_d_d = pick_d;
        we_d    = pick_d & d_we;
        base_d  = pick_d ? d_addr[AW-1:OW] : i_addr[AW-1:OW];
        lat_d   = '0;
        cnt_d   = '0;
`ifdef ARB_RR_EN
        cont_d  = i_req & d_req;
`endif
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = S_BURST;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 5'd1;
        end
      end
      S_BURST: begin
        if (mem_en) cnt_d = cnt_q + 1'b1;
        if (we_q ? (mem_en && cnt_q[BW-1:0] == LAST_BEAT) : (rvalid_q && rvidx_q == LAST_BEAT))
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef ARB_RR_EN
        if (cont_q) pri_i_d = ~pri_i_q;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      own_d_q  <= 1'b0;
      we_q     <= 1'b0;
      base_q   <= '0;
      lat_q    <= '0;
      cnt_q    <= '0;
      rpend_q  <= 1'b0;
      ridx_q   <= '0;
      rvalid_q <= 1'b0;
      rvidx_q  <= '0;
      rdata_q  <= '0;
`ifdef ARB_RR_EN
      pri_i_q  <= 1'b0;
      cont_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      own_d_q  <= own_d_d;
      we_q     <= we_d;
      base_q   <= base_d;
      lat_q    <= lat_d;
      cnt_q    <= cnt_d;
      // read beat: memory answers the cycle after mem_en, then rdata is registered
      rpend_q  <= mem_en & ~we_q;
      ridx_q   <= cnt_q[BW-1:0];
      rvalid_q <= rpend_q;
      rvidx_q  <= ridx_q;
      if (rpend_q) rdata_q <= mem_rdata;
`ifdef ARB_RR_EN
      pri_i_q  <= pri_i_d;
      cont_q   <= cont_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-timeline reference model.
module tb_mem_arbiter;
  localparam int unsigned LW  = 4;
  localparam int unsigned LAT = 5;
  localparam int unsigned AW  = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [31:0]   d_wdata, rnd_wdata = '0;
  logic          wb_mode = 1'b0;
  logic          i_gnt, d_gnt, beat_valid, i_done, d_done, mem_en, mem_we, mem_ready;
  logic [1:0]    beat_idx;
  logic [31:0]   rdata, mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WORDS(LW), .MEM_LATENCY(LAT), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .beat_valid(beat_valid), .beat_idx(beat_idx),
    .rdata(rdata), .i_done(i_done), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Synchronous memory: data for a strobed address appears the following cycle
  always @(posedge clk) mem_rdata <= mem_en ? mem_fn(mem_addr) : 32'h0;

  assign d_wdata = wb_mode ? (32'hA0 + 32'(beat_idx)) : rnd_wdata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is a timeline of r = cycles since grant rose
  bit          m_busy = 0, m_own_d = 0, m_we = 0, m_pri_i = 0, m_cont = 0;
  int unsigned m_r = 0;
  logic [31:0] m_base = '0;

  logic        s_ig, s_dg, s_en, s_we, s_bv, s_id, s_dd, s_rdy;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_idx;
  bit          prev_ig = 0, prev_dg = 0;
  byte         gq[$];
  int          cyc = 0, ig_rise = 0, ddone_cyc = 0, n_idone = 0, n_ddone = 0;

  task automatic tick();
    logic [31:0] e_addr, e_wdata;
    logic        e_ig, e_dg, e_en, e_we, e_bv, e_id, e_dd, e_rdy;
    int unsigned e_idx, tdone;
    bit          pd;
    @(negedge clk);
    e_addr = '0; e_wdata = '0; e_idx = 0;
    e_ig = 0; e_dg = 0; e_en = 0; e_we = 0; e_bv = 0; e_id = 0; e_dd = 0;
    e_rdy = reset ? (!m_busy && !i_req && !d_req) : 1'b1;
    tdone = m_we ? LAT + LW : LAT + LW + 2;
    if (reset && m_busy) begin
      e_ig = !m_own_d;
      e_dg = m_own_d;
      if (m_r >= LAT && m_r < LAT + LW) begin
        e_en   = 1;
        e_addr = m_base + 32'(4 * (m_r - LAT));
        if (m_we) begin
          e_we = 1; e_wdata = d_wdata; e_bv = 1; e_idx = m_r - LAT;
        end
      end
      if (!m_we && m_r >= LAT + 2 && m_r < LAT + LW + 2) begin
        e_bv  = 1;
        e_idx = m_r - LAT - 2;
        chk("rdata", rdata, mem_fn(m_base + 32'(4 * e_idx)));
      end
      if (m_r == tdone) begin
        e_id = !m_own_d; e_dd = m_own_d;
      end
    end
    if (!reset) chk("rdata_reset", rdata, 32'h0);
    chk("i_gnt", 32'(i_gnt), 32'(e_ig));
    chk("d_gnt", 32'(d_gnt), 32'(e_dg));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("beat_valid", 32'(beat_valid), 32'(e_bv));
    chk("beat_idx", 32'(beat_idx), e_idx);
    chk("i_done", 32'(i_done), 32'(e_id));
    chk("d_done", 32'(d_done), 32'(e_dd));
    chk("mem_ready", 32'(mem_ready), 32'(e_rdy));

    s_ig = i_gnt; s_dg = d_gnt; s_en = mem_en; s_we = mem_we; s_bv = beat_valid;
    s_id = i_done; s_dd = d_done; s_rdy = mem_ready; s_addr = mem_addr;
    s_wdata = mem_wdata; s_idx = beat_idx;
    cyc++;
    if (s_ig && !prev_ig) begin gq.push_back(8'h49); ig_rise = cyc; end
    if (s_dg && !prev_dg) gq.push_back(8'h44);
    if (s_dd) ddone_cyc = cyc;
    n_idone += int'(s_id);
    n_ddone += int'(s_dd);
    prev_ig = s_ig; prev_dg = s_dg;

    if (!reset) begin
      m_busy = 0; m_pri_i = 0; m_cont = 0;
    end else if (!m_busy) begin
      if (i_req || d_req) begin
`ifdef ARB_RR_EN
        pd = d_req && !(i_req && m_pri_i);
`else
        pd = d_req;
`endif
        m_busy = 1; m_r = 0; m_own_d = pd; m_we = pd && d_we;
        m_base = (pd ? d_addr : i_addr) & ~32'(LW * 4 - 1);
        m_cont = i_req && d_req;
      end
    end else if (m_r == tdone) begin
      m_busy = 0;
`ifdef ARB_RR_EN
      if (m_cont) m_pri_i = !m_pri_i;
`endif
    end else begin
      m_r++;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          req;
    bit          ig;
    bit          en;
    logic [31:0] addr;
    bit          bv;
    logic [1:0]  idx;
    bit          done;
    bit          rdy;
  } vec_t;

  vec_t tv[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbeats;
    bit got;
    logic [31:0] first_addr;
    byte exp2a, exp2b;

    tv[0] = '{1, 0, 0, 32'h0, 0, 0, 0, 0};
    for (int k = 1; k <= 5; k++) tv[k] = '{1, 1, 0, 32'h0, 0, 0, 0, 0};
    tv[6]  = '{1, 1, 1, 32'h1000, 0, 0, 0, 0};
    tv[7]  = '{1, 1, 1, 32'h1004, 0, 0, 0, 0};
    tv[8]  = '{1, 1, 1, 32'h1008, 1, 0, 0, 0};
    tv[9]  = '{1, 1, 1, 32'h100C, 1, 1, 0, 0};
    tv[10] = '{1, 1, 0, 32'h0,    1, 2, 0, 0};
    tv[11] = '{1, 1, 0, 32'h0,    1, 3, 0, 0};
    tv[12] = '{1, 1, 0, 32'h0,    0, 0, 1, 0};
    tv[13] = '{0, 0, 0, 32'h0,    0, 0, 0, 1};

    @(posedge clk); #1;
    tick(); tick();
    chk("reset mem_ready", 32'(s_rdy), 32'h1);
    reset = 1'b1;
    tick();

    // I refill from 0x1004: line base 0x1000, done 11 cycles after grant rises
    i_addr = 32'h1004;
    for (int k = 0; k < 14; k++) begin
      i_req = tv[k].req;
      tick();
      chk($sformatf("t1[%0d] i_gnt", k), 32'(s_ig), 32'(tv[k].ig));
      chk($sformatf("t1[%0d] mem_en", k), 32'(s_en), 32'(tv[k].en));
      chk($sformatf("t1[%0d] mem_addr", k), s_addr, tv[k].addr);
      chk($sformatf("t1[%0d] beat_valid", k), 32'(s_bv), 32'(tv[k].bv));
      chk($sformatf("t1[%0d] beat_idx", k), 32'(s_idx), 32'(tv[k].idx));
      chk($sformatf("t1[%0d] i_done", k), 32'(s_id), 32'(tv[k].done));
      chk($sformatf("t1[%0d] mem_ready", k), 32'(s_rdy), 32'(tv[k].rdy));
    end

    // D write-back of 0x2000 with beat-indexed data
    wb_mode = 1; d_addr = 32'h2000; d_we = 1; d_req = 1; nbeats = 0;
    for (int c = 0; c < 30 && d_req; c++) begin
      tick();
      if (s_we) begin
        chk("t2 wdata", s_wdata, 32'hA0 + 32'(nbeats));
        chk("t2 addr", s_addr, 32'h2000 + 32'(4 * nbeats));
        nbeats++;
      end
      if (s_dd) d_req = 0;
    end
    chk("t2 beats", 32'(nbeats), 32'd4);
    chk("t2 finished", 32'(d_req), 32'h0);
    wb_mode = 0; d_we = 0;
    tick();

    // Simultaneous requests, twice
`ifdef ARB_RR_EN
    exp2a = 8'h49; exp2b = 8'h44;
`else
    exp2a = 8'h44; exp2b = 8'h49;
`endif
    for (int rnd = 0; rnd < 2; rnd++) begin
      gq.delete();
      i_addr = 32'h3000; d_addr = 32'h4000; i_req = 1; d_req = 1;
      for (int c = 0; c < 60 && (i_req || d_req); c++) begin
        tick();
        if (s_id) i_req = 0;
        if (s_dd) d_req = 0;
      end
      chk($sformatf("t3.%0d finished", rnd), {30'h0, i_req, d_req}, 32'h0);
      chk($sformatf("t3.%0d grants", rnd), 32'(gq.size()), 32'd2);
      chk($sformatf("t3.%0d first", rnd), 32'(gq[0]), 32'(rnd == 0 ? 8'h44 : exp2a));
      chk($sformatf("t3.%0d second", rnd), 32'(gq[1]), 32'(rnd == 0 ? 8'h49 : exp2b));
      if (rnd == 0) chk("t3 idle gap", 32'(ig_rise - ddone_cyc), 32'd2);
      tick();
    end

    // Reset during beat 2 of an I refill, request held across reset
    i_addr = 32'h5004; i_req = 1;
    for (int c = 0; c < 8; c++) tick();
    chk("t4 beat2 addr", mem_addr, 32'h5008);
    reset = 0;
    #1;
    chk("t4 i_gnt", 32'(i_gnt), 32'h0);
    chk("t4 mem_en", 32'(mem_en), 32'h0);
    chk("t4 i_done", 32'(i_done), 32'h0);
    chk("t4 mem_ready", 32'(mem_ready), 32'h1);
    tick(); tick();
    reset = 1; n_idone = 0; got = 0; first_addr = '0;
    for (int c = 0; c < 30 && n_idone == 0; c++) begin
      tick();
      if (s_en && !got) begin got = 1; first_addr = s_addr; end
    end
    i_req = 0;
    chk("t4 restart addr", first_addr, 32'h5000);
    chk("t4 dones", 32'(n_idone), 32'd1);
    tick();

    // I request dropped while waiting on latency
    i_addr = 32'h6000; i_req = 1;
    tick(); tick(); tick();
    i_req = 0; n_idone = 0;
    for (int c = 0; c < 25; c++) tick();
    chk("t5 dones", 32'(n_idone), 32'd1);

    // Randomized traffic with rare asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      if (i_req) begin
        if (s_id || $urandom_range(0, 15) == 0) i_req = 0;
      end else i_req = ($urandom_range(0, 3) == 0);
      if (d_req) begin
        if (s_dd || $urandom_range(0, 15) == 0) d_req = 0;
      end else d_req = ($urandom_range(0, 3) == 0);
      i_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
      rnd_wdata = $urandom;
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
